// File: rtl/sprite_pkg.sv
// Shared types and sprite codes for the sprite action controller.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUNCH,
        JUMP,
        JUMP_PUNCH,
        COOLDOWN
    } action_state_t;

    localparam logic [2:0] SPR_IDLE  = 3'b000;
    localparam logic [2:0] SPR_PUNCH = 3'b001;
    localparam logic [2:0] SPR_JUMP  = 3'b010;

endpackage

// File: rtl/btn_press_detect.sv
// Frame-tick-gated rising-edge detector: a press is a 0->1 change between two tick samples.
module btn_press_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o
);

    logic hist_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hist_q <= 1'b0;
        end else if (tick_i) begin
            hist_q <= btn_i;
        end
    end

    assign press_o = tick_i & btn_i & ~hist_q;

endmodule

// File: rtl/sprite_action_ctrl.sv
// Per-frame punch/jump action sequencer driving sprite select and jump-arc height.
//   state      | meaning
//   IDLE       | standing, accepts jump or punch press
//   PUNCH      | punch sprite held for PUNCH_FRAMES ticks
//   JUMP       | airborne, a punch press switches to JUMP_PUNCH
//   JUMP_PUNCH | airborne with punch sprite, arc continues
//   COOLDOWN   | lockout for COOLDOWN_FRAMES ticks after any action
module sprite_action_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned PUNCH_FRAMES    = 8,
    parameter int unsigned JUMP_FRAMES     = 16,
    parameter int unsigned COOLDOWN_FRAMES = 4,
    parameter int unsigned JUMP_STEP       = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       punch,
    input  logic       jump,
    output logic [2:0] spriteIndex,
    output logic [7:0] y_offset,
    output logic       busy
);

    localparam logic [4:0] PUNCH_LAST = 5'(PUNCH_FRAMES - 1);
    localparam logic [4:0] JUMP_LAST  = 5'(JUMP_FRAMES - 1);
    localparam logic [4:0] COOL_LAST  = 5'(COOLDOWN_FRAMES - 1);
    localparam logic [4:0] JUMP_HALF  = 5'(JUMP_FRAMES / 2);
    localparam logic [7:0] JUMP_LAST8 = 8'(JUMP_FRAMES - 1);
    localparam logic [7:0] STEP8      = 8'(JUMP_STEP);

    action_state_t state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          punch_press, jump_press;
    logic [7:0]    cnt_w;

    btn_press_detect u_punch_det (
        .clk_i   (Clk),
        .reset_i (Reset),
        .tick_i  (frame_tick),
        .btn_i   (punch),
        .press_o (punch_press)
    );

    btn_press_detect u_jump_det (
        .clk_i   (Clk),
        .reset_i (Reset),
        .tick_i  (frame_tick),
        .btn_i   (jump),
        .press_o (jump_press)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (jump_press) begin
                        state_d = JUMP;
                        cnt_d   = '0;
                    end else if (punch_press) begin
                        state_d = PUNCH;
                        cnt_d   = '0;
                    end
                end
                PUNCH: begin
                    if (cnt_q == PUNCH_LAST) begin
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                JUMP: begin
                    // Landing takes priority over a punch arriving on the final tick.
                    if (cnt_q == JUMP_LAST) begin
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        if (punch_press) state_d = JUMP_PUNCH;
                    end
                end
                JUMP_PUNCH: begin
                    if (cnt_q == JUMP_LAST) begin
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_w = {3'b000, cnt_q};

    always_comb begin
        spriteIndex = SPR_IDLE;
        y_offset    = 8'd0;
        busy        = (state_q != IDLE);
        case (state_q)
            PUNCH:      spriteIndex = SPR_PUNCH;
            JUMP:       spriteIndex = SPR_JUMP;
            JUMP_PUNCH: spriteIndex = SPR_PUNCH;
            default:    spriteIndex = SPR_IDLE;
        endcase
        if (state_q == JUMP || state_q == JUMP_PUNCH) begin
            if (cnt_q < JUMP_HALF) y_offset = STEP8 * cnt_w;
            else                   y_offset = STEP8 * (JUMP_LAST8 - cnt_w);
        end
    end

endmodule

// File: doc/sprite_action_ctrl.md
SPRITE_ACTION_CTRL -- requirements
Module: sprite_action_ctrl

Interface
REQ-001 Parameter PUNCH_FRAMES, 8: frame ticks the punch sprite is held (legal 2..31).
REQ-002 Parameter JUMP_FRAMES, 16: frame ticks airborne; even, legal 4..30.
REQ-003 Parameter COOLDOWN_FRAMES, 4: frame ticks of lockout after any action (legal 1..31).
REQ-004 Parameter JUMP_STEP, 2: pixels of height per tick of jump arc (legal 1..7).
REQ-005 Clk  input  1  system clock; single clock domain.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-Clk-wide pulse per video frame; all state advance is gated by it.
REQ-008 punch  input  1  punch button level, synchronous to Clk.
REQ-009 jump  input  1  jump button level, synchronous to Clk.
REQ-010 spriteIndex  output  3  sprite select: 000 idle, 001 punch, 010 jump.
REQ-011 y_offset  output  8  upward pixel displacement of the sprite, unsigned.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, PUNCH, JUMP, JUMP_PUNCH, COOLDOWN; state, 5-bit frame counter cnt and button history regs update only on Clk edges where frame_tick=1.
REQ-014 Buttons SHALL be sampled only at frame_tick; a press is a rising edge between consecutive tick samples (sample=1, previous sample=0); held buttons never retrigger.
REQ-015 IDLE: jump press (with or without punch press) -> JUMP, cnt=0; punch press alone -> PUNCH, cnt=0; otherwise stay.
REQ-016 PUNCH: tick with cnt=PUNCH_FRAMES-1 -> COOLDOWN, cnt=0; else cnt+1; jump presses ignored.
REQ-017 JUMP: punch press -> JUMP_PUNCH, cnt keeps counting (cnt+1); tick with cnt=JUMP_FRAMES-1 -> COOLDOWN, cnt=0 (expiry wins over simultaneous punch press).
REQ-018 JUMP_PUNCH: tick with cnt=JUMP_FRAMES-1 -> COOLDOWN, cnt=0; else cnt+1; all presses ignored.
REQ-019 COOLDOWN: tick with cnt=COOLDOWN_FRAMES-1 -> IDLE, cnt=0; else cnt+1; presses ignored but history regs still update.
REQ-020 spriteIndex SHALL decode from state: IDLE/COOLDOWN 000, PUNCH 001, JUMP 010, JUMP_PUNCH 001.
REQ-021 y_offset in JUMP/JUMP_PUNCH SHALL be JUMP_STEP*cnt for cnt<JUMP_FRAMES/2, else JUMP_STEP*(JUMP_FRAMES-1-cnt); 0 in all other states; arc symmetric, peak at cnt=JUMP_FRAMES/2-1 and JUMP_FRAMES/2.
REQ-022 Outputs SHALL be combinational decode of registered state/cnt only: change visible the cycle after the ticking edge, no input-to-output combinational path.
REQ-023 Products SHALL be computed at 8 bits; parameter ranges guarantee no overflow (max 7*14=98).
REQ-024 frame_tick held high multiple cycles SHALL advance once per cycle (no internal tick edge detect).

Reset
REQ-025 Reset=1 at a Clk edge SHALL force state IDLE, cnt=0, both history regs 0, regardless of frame_tick or state (including mid-jump).
REQ-026 After reset: spriteIndex=000, y_offset=0, busy=0; a button held through reset release SHALL register as a press at the first tick.

Structure
REQ-027 Shared package sprite_pkg SHALL hold the action state enum (action_state_t) and sprite code constants SPR_IDLE, SPR_PUNCH, SPR_JUMP.
REQ-028 One sub-module, btn_press_detect (tick-gated rising-edge detector with history reg), SHALL be instantiated once per button.

Verification
REQ-029 Defaults, punch pressed for one tick from IDLE -> spriteIndex=001 for 8 ticks, then 000 with busy=1 for 4 ticks, then busy=0.
REQ-030 Jump press -> spriteIndex=010, y_offset sequence 0,2,4,...,14,14,12,...,0 over 16 ticks, then COOLDOWN 4 ticks.
REQ-031 Jump press, punch press at 5th jump tick -> spriteIndex 010 for ticks 1-4, 001 from tick 5 to jump end, y_offset arc unbroken, total airborne 16 ticks.
REQ-032 punch and jump both rising on same tick in IDLE -> JUMP (010); punch held continuously through a full punch+cooldown -> no second punch.
REQ-033 Reset asserted at jump cnt=6 -> next cycle spriteIndex=000, y_offset=0, busy=0; jump still held -> new jump at first tick.
REQ-034 Buttons toggled between ticks with frame_tick=0 -> no state change; punch press during COOLDOWN -> ignored, returns to IDLE on schedule.
